// File: rtl/imuldiv_mul_arbiter_if.sv
// Request/response channel between a multiply requester (master) and its server (slave).
// Carries two operands on the request side and the double-width product on the response side.
interface imuldiv_mul_arbiter_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0]   msg_a;
    logic [DATA_W-1:0]   msg_b;
    logic                req_val;
    logic                req_rdy;
    logic [2*DATA_W-1:0] msg_result;
    logic                resp_val;
    logic                resp_rdy;

    modport master (
        output msg_a, msg_b, req_val, resp_rdy,
        input  req_rdy, msg_result, resp_val
    );

    modport slave (
        input  msg_a, msg_b, req_val, resp_rdy,
        output req_rdy, msg_result, resp_val
    );
endinterface

// File: rtl/imuldiv_mul_arbiter.sv
// Round-robin arbiter sharing one iterative multiply unit between two requesters, one transaction in flight.
// Optional macro IMULDIV_ARB_ZERO_BYPASS_EN: zero operands skip the unit and answer 0 directly.
module imuldiv_mul_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    imuldiv_mul_arbiter_if.slave  req0,
    imuldiv_mul_arbiter_if.slave  req1,
    imuldiv_mul_arbiter_if.master mul
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                owner_q, owner_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [2*DATA_W-1:0] result_q, result_d;

    logic                grant;
    logic                accept;
    logic                owner_rdy;
    logic [DATA_W-1:0]   acc_a;
    logic [DATA_W-1:0]   acc_b;

    // A lone requester always wins; a tie goes to the port that did not finish last.
    always_comb begin
        if (req0.req_val && req1.req_val) grant = ~last_grant_q;
        else                              grant = req1.req_val;
        accept    = (state_q == IDLE) && !reset && (req0.req_val || req1.req_val);
        acc_a     = grant ? req1.msg_a : req0.msg_a;
        acc_b     = grant ? req1.msg_b : req0.msg_b;
        owner_rdy = owner_q ? req1.resp_rdy : req0.resp_rdy;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        a_d          = a_q;
        b_d          = b_q;
        result_d     = result_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = acc_a;
                    b_d     = acc_b;
                    owner_d = grant;
                    state_d = ISSUE;
`ifdef IMULDIV_ARB_ZERO_BYPASS_EN
                    if (acc_a == '0 || acc_b == '0) begin
                        result_d = '0;
                        state_d  = RESP;
                    end
`endif
                end
            end
            ISSUE: begin
                if (mul.req_rdy) state_d = WAIT;
            end
            WAIT: begin
                if (mul.resp_val) begin
                    result_d = mul.msg_result;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (owner_rdy) begin
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            a_q          <= a_d;
            b_q          <= b_d;
            result_q     <= result_d;
        end
    end

    // Handshake outputs are forced low while reset is high, even mid-transaction.
    assign req0.req_rdy     = accept && !grant;
    assign req1.req_rdy     = accept && grant;
    assign mul.req_val      = !reset && (state_q == ISSUE);
    assign mul.msg_a        = a_q;
    assign mul.msg_b        = b_q;
    assign mul.resp_rdy     = !reset && (state_q == WAIT);
    assign req0.resp_val    = !reset && (state_q == RESP) && !owner_q;
    assign req1.resp_val    = !reset && (state_q == RESP) && owner_q;
    assign req0.msg_result  = reset ? '0 : result_q;
    assign req1.msg_result  = reset ? '0 : result_q;
endmodule

// File: tb/tb_imuldiv_mul_arbiter.sv
// Bench for imuldiv_mul_arbiter: behavioural 32-cycle signed multiplier plus a response scoreboard.
module tb_imuldiv_mul_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    imuldiv_mul_arbiter_if #(.DATA_W(32)) p0 ();
    imuldiv_mul_arbiter_if #(.DATA_W(32)) p1 ();
    imuldiv_mul_arbiter_if #(.DATA_W(32)) mu ();

    imuldiv_mul_arbiter #(.DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .req0  (p0),
        .req1  (p1),
        .mul   (mu)
    );

    typedef struct {
        int          port;
        logic [63:0] res;
    } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad = 0;
    int n_resp0 = 0;
    int n_resp1 = 0;

    // Multiply unit model: optional request stall, then result 32 cycles after accept.
    int          stall_cfg = 0;
    int          u_stalled;
    bit          u_busy;
    int          u_cnt;
    logic [63:0] u_prod;
    int          unit_reqs = 0;

    assign mu.req_rdy = !reset && !u_busy && (u_stalled >= stall_cfg);

    always @(posedge clk) begin
        if (reset) begin
            u_busy        <= 1'b0;
            u_stalled     <= 0;
            u_cnt         <= 0;
            mu.resp_val   <= 1'b0;
            mu.msg_result <= '0;
        end else begin
            if (mu.req_val && mu.req_rdy) begin
                u_busy    <= 1'b1;
                u_cnt     <= 0;
                u_stalled <= 0;
                unit_reqs <= unit_reqs + 1;
                u_prod    <= $signed({{32{mu.msg_a[31]}}, mu.msg_a}) * $signed({{32{mu.msg_b[31]}}, mu.msg_b});
            end else if (mu.req_val && !u_busy) begin
                u_stalled <= u_stalled + 1;
            end
            if (u_busy && !mu.resp_val) begin
                u_cnt <= u_cnt + 1;
                if (u_cnt == 31) begin
                    mu.resp_val   <= 1'b1;
                    mu.msg_result <= u_prod;
                end
            end
            if (mu.resp_val && mu.resp_rdy) begin
                mu.resp_val <= 1'b0;
                u_busy      <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (p0.resp_val || p1.resp_val)
                    chk("resp_val_exclusive", 64'(p0.resp_val & p1.resp_val), 64'd0);
                if (mu.resp_val)
                    chk("mulresp_outside_wait", 64'(mu.resp_rdy), 64'd1);
                if (p0.resp_val && p0.resp_rdy) begin
                    n_resp0++;
                    if (exp_q.size() == 0) chk("resp0_unexpected", 64'd1, 64'd0);
                    else begin
                        e = exp_q.pop_front();
                        chk("resp0_port", 64'd0, 64'(e.port));
                        chk("resp0_result", p0.msg_result, e.res);
                    end
                end
                if (p1.resp_val && p1.resp_rdy) begin
                    n_resp1++;
                    if (exp_q.size() == 0) chk("resp1_unexpected", 64'd1, 64'd0);
                    else begin
                        e = exp_q.pop_front();
                        chk("resp1_port", 64'd1, 64'(e.port));
                        chk("resp1_result", p1.msg_result, e.res);
                    end
                end
            end
        end
    endtask

    task automatic do_req(input int port, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] res, input bit push);
        int n = 0;
        @(posedge clk); #1;
        if (port == 0) begin p0.msg_a = a; p0.msg_b = b; p0.req_val = 1'b1; end
        else           begin p1.msg_a = a; p1.msg_b = b; p1.req_val = 1'b1; end
        do begin
            @(negedge clk);
            n++;
        end while (!(port == 0 ? p0.req_rdy : p1.req_rdy) && n < 200);
        if (n >= 200) chk("req_accept_timeout", 64'd1, 64'd0);
        else if (push) exp_q.push_back('{port, res});
        @(posedge clk); #1;
        // Scribble operands after accept; the arbiter must not pick these up.
        if (port == 0) begin p0.req_val = 1'b0; p0.msg_a = 32'hDEADBEEF; p0.msg_b = 32'hCAFEF00D; end
        else           begin p1.req_val = 1'b0; p1.msg_a = 32'hDEADBEEF; p1.msg_b = 32'hCAFEF00D; end
    endtask

    task automatic do_pair(input logic [31:0] a0, input logic [31:0] b0, input logic [63:0] r0,
                           input logic [31:0] a1, input logic [31:0] b1, input logic [63:0] r1,
                           input int first);
        int n = 0;
        @(posedge clk); #1;
        p0.msg_a = a0; p0.msg_b = b0; p0.req_val = 1'b1;
        p1.msg_a = a1; p1.msg_b = b1; p1.req_val = 1'b1;
        @(negedge clk);
        chk("grant_p0_rdy", 64'(p0.req_rdy), 64'(first == 0));
        chk("grant_p1_rdy", 64'(p1.req_rdy), 64'(first == 1));
        if (first == 0) exp_q.push_back('{0, r0});
        else            exp_q.push_back('{1, r1});
        @(posedge clk); #1;
        if (first == 0) p0.req_val = 1'b0; else p1.req_val = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!(first == 0 ? p1.req_rdy : p0.req_rdy) && n < 200);
        if (n >= 200) chk("pair_second_timeout", 64'd1, 64'd0);
        else if (first == 0) exp_q.push_back('{1, r1});
        else                 exp_q.push_back('{0, r0});
        @(posedge clk); #1;
        p0.req_val = 1'b0;
        p1.req_val = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk(name, 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    initial begin
        int u0, r0, r1, n;
        p0.req_val = 1'b1; p0.msg_a = 32'd1; p0.msg_b = 32'd1; p0.resp_rdy = 1'b1;
        p1.req_val = 1'b1; p1.msg_a = 32'd1; p1.msg_b = 32'd1; p1.resp_rdy = 1'b1;
        fork monitor(); join_none

        // Reset state with both requesters already asserting valid.
        @(negedge clk);
        chk("rst_req0_rdy", 64'(p0.req_rdy), 64'd0);
        chk("rst_req1_rdy", 64'(p1.req_rdy), 64'd0);
        chk("rst_mulreq_val", 64'(mu.req_val), 64'd0);
        chk("rst_mulresp_rdy", 64'(mu.resp_rdy), 64'd0);
        chk("rst_resp_val", 64'({p0.resp_val, p1.resp_val}), 64'd0);
        chk("rst_result", p0.msg_result, 64'd0);
        @(posedge clk); #1;
        p0.req_val = 1'b0; p1.req_val = 1'b0;
        @(posedge clk); #1 reset = 1'b0;

        // Single request on port 0.
        r1 = n_resp1; r0 = n_resp0;
        do_req(0, 32'd3, 32'd7, 64'd21, 1'b1);
        drain("single_drain");
        chk("single_resp0_count", 64'(n_resp0 - r0), 64'd1);
        chk("single_resp1_none", 64'(n_resp1 - r1), 64'd0);

        // Signed operands on port 1.
        do_req(1, 32'hFFFFFFFB, 32'd6, 64'hFFFFFFFFFFFFFFE2, 1'b1);
        drain("signed_drain");

        // Contention after reset: 0 first, then 1, then 0 again on the next tie.
        do_reset();
        do_pair(32'd2, 32'd3, 64'd6, 32'd4, 32'd5, 64'd20, 0);
        drain("pair1_drain");
        do_pair(32'd7, 32'd8, 64'd56, 32'd9, 32'd9, 64'd81, 0);
        drain("pair2_drain");

        // Backpressure from the unit and from the requester.
        stall_cfg = 5; p0.resp_rdy = 1'b0;
        u0 = unit_reqs; r0 = n_resp0;
        do_req(0, 32'd11, 32'd13, 64'd143, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_mulreq_val", 64'(mu.req_val), 64'd1);
            chk("bp_mulreq_rdy", 64'(mu.req_rdy), 64'd0);
            chk("bp_msg_a", 64'(mu.msg_a), 64'd11);
            chk("bp_msg_b", 64'(mu.msg_b), 64'd13);
        end
        n = 0;
        while (!p0.resp_val && n < 100) begin @(negedge clk); n++; end
        for (int i = 0; i < 4; i++) begin
            chk("bp_resp_val_held", 64'(p0.resp_val), 64'd1);
            chk("bp_resp_result_held", p0.msg_result, 64'd143);
            @(negedge clk);
        end
        @(posedge clk); #1 p0.resp_rdy = 1'b1;
        drain("bp_drain");
        stall_cfg = 0;
        chk("bp_unit_transfers", 64'(unit_reqs - u0), 64'd1);
        chk("bp_resp_transfers", 64'(n_resp0 - r0), 64'd1);

        // Reset while waiting on the unit.
        do_req(0, 32'd100, 32'd100, 64'd0, 1'b0);
        n = 0;
        while (!mu.resp_rdy && n < 100) begin @(negedge clk); n++; end
        chk("midrst_in_wait", 64'(mu.resp_rdy), 64'd1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_mulreq_val", 64'(mu.req_val), 64'd0);
        chk("midrst_mulresp_rdy", 64'(mu.resp_rdy), 64'd0);
        chk("midrst_resp_val", 64'({p0.resp_val, p1.resp_val}), 64'd0);
        @(posedge clk); #1;
        p0.msg_a = 32'd2; p0.msg_b = 32'd2; p0.req_val = 1'b1;
        @(negedge clk);
        chk("midrst_idle_rdy", 64'(p0.req_rdy), 64'd1);
        exp_q.push_back('{0, 64'd4});
        @(posedge clk); #1 p0.req_val = 1'b0;
        drain("midrst_drain");

        // Zero operand.
        u0 = unit_reqs;
        do_req(0, 32'd0, 32'd9, 64'd0, 1'b1);
        @(negedge clk);
`ifdef IMULDIV_ARB_ZERO_BYPASS_EN
        chk("zero_bypass_resp_val", 64'(p0.resp_val), 64'd1);
        drain("zero_drain");
        chk("zero_bypass_unit_untouched", 64'(unit_reqs - u0), 64'd0);
`else
        chk("zero_issue_mulreq_val", 64'(mu.req_val), 64'd1);
        drain("zero_drain");
        chk("zero_unit_used", 64'(unit_reqs - u0), 64'd1);
`endif
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/imuldiv_mul_arbiter.md
Name: imuldiv_mul_arbiter

Overview:
- Shares one iterative multiply unit (32-cycle, val/rdy on request and response) between two requesters, port 0 and port 1.
- Accepts one request at a time and registers its operands.
- Issues the request to the unit, captures the 64-bit result, and returns it to the owning port.
- Resolves contention by round-robin.
- Sits between the pipeline/requesters and the multiply datapath+control pair. At most one transaction is outstanding.

Parameters:
- DATA_W, 32, operand width; result width is 2*DATA_W.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req0_msg_a  in  DATA_W  port 0 operand A
- req0_msg_b  in  DATA_W  port 0 operand B
- req0_val  in  1  port 0 request valid
- req0_rdy  out  1  port 0 request ready
- resp0_msg_result  out  2*DATA_W  port 0 result
- resp0_val  out  1  port 0 response valid
- resp0_rdy  in  1  port 0 response ready
- req1_msg_a, req1_msg_b, req1_val, req1_rdy, resp1_msg_result, resp1_val, resp1_rdy: same as port 0, for port 1
- mulreq_msg_a  out  DATA_W  operand A to multiply unit
- mulreq_msg_b  out  DATA_W  operand B to multiply unit
- mulreq_val  out  1  request valid to unit
- mulreq_rdy  in  1  unit ready
- mulresp_msg_result  in  2*DATA_W  unit result
- mulresp_val  in  1  unit response valid
- mulresp_rdy  out  1  ready to unit

Behaviour:
- Clocking/reset: single clock clk; reset synchronous, active-high, sampled on posedge clk.
- Reset values: state=IDLE, last_grant=1 (so port 0 wins the first tie), owner=0, operand/result regs=0. All rdy/val outputs are 0 the cycle reset is high. Result outputs=0.
- FSM states: IDLE, ISSUE, WAIT, RESP. Transfer on any interface = val && rdy at posedge.
- IDLE, grant selection (combinational):
  - only req0_val set -> grant 0; only req1_val set -> grant 1.
  - both set -> grant = ~last_grant.
  - reqN_rdy=1 only for the granted port, and only in IDLE; the other rdy=0.
- IDLE, on accept:
  - latch a, b and owner=grant; go to ISSUE.
  - last_grant is not updated here.
- ISSUE:
  - mulreq_val=1; mulreq_msg_a/b driven from the operand regs (stable until transfer).
  - On mulreq_rdy -> WAIT.
- WAIT:
  - mulresp_rdy=1.
  - On mulresp_val, latch mulresp_msg_result into the result reg -> RESP.
- RESP:
  - resp{owner}_val=1; the other resp_val=0.
  - Both resp*_msg_result are driven from the result reg (only the owner's val qualifies it).
  - On resp{owner}_rdy: last_grant<=owner -> IDLE.
  - A held response never blocks the other port's response path except by occupancy.
- Outside their states, mulreq_val and mulresp_rdy are 0.
- Minimum overhead: 3 cycles beyond the unit latency (accept→ISSUE, WAIT→RESP capture, RESP→IDLE). No new request is accepted in the RESP cycle.
- Requester drops reqN_val while not granted: no effect, nothing latched.
- Operand changes after accept: ignored.
- mulresp_val arriving outside WAIT: ignored (protocol violation, flagged by the bench).
- Reset mid-transaction: return to IDLE immediately and discard the transaction. The unit shares the same reset, so no stale response is expected.
- Fairness: under continuous contention, grants alternate 0,1,0,1…

Optional Feature:
- Macro IMULDIV_ARB_ZERO_BYPASS_EN.
- Defined: at accept, if the accepted a==0 or b==0, go directly from IDLE to RESP with result reg=0. The unit is not touched (mulreq_val stays 0); response is visible the cycle after accept.
- Undefined: every request goes through ISSUE/WAIT regardless of operand values.

Test Plan:
- Single request: port 0, a=3, b=7; unit responds after 32 cycles -> resp0_val with result 64'd21; resp1_val never asserted; FSM returns to IDLE.
- Signed request: port 1, a=32'hFFFFFFFB (-5), b=6 -> resp1_msg_result=64'hFFFFFFFFFFFFFFE2 (-30), owner=1.
- Contention after reset: req0 and req1 both valid in the same cycle -> port 0 granted first. Port 1 is granted after resp0 completes. A third simultaneous pair is granted to port 0, proving alternation.
- Backpressure: hold mulreq_rdy=0 for 5 cycles in ISSUE, then hold resp0_rdy=0 for 4 cycles in RESP -> operands and result stay stable; exactly one transfer each on the unit and on the response.
- Reset mid-op: assert reset in WAIT -> next cycle all val/rdy=0 and state=IDLE. A new request a=2, b=2 then returns 64'd4.
- Zero bypass: with IMULDIV_ARB_ZERO_BYPASS_EN, a=0, b=9 -> resp0_val the cycle after accept, result 0, mulreq_val never asserted. Without the macro, the same request goes through the unit and result=0.
